// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM controller: FSM sequencing, ALU decode, NZCV flags and condition gating.
// Optional feature macro ARM_MCC_CMP_EN: decode cmd 1010 as a flag-only CMP.
module arm_multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cmd;
  logic        imm_bit;
  logic        load_bit;
  logic        s_bit;
  logic        unused_bits;

  logic [3:0]  flags;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_ex;
  logic        cond_ex_r;

  logic [1:0]  flag_w;
  logic [1:0]  alu_op;
  logic        is_cmp;

  logic        ir_w;
  logic        fetch_pc;
  logic        reg_w;
  logic        mem_w;
  logic        branch;

  // Field extraction; Instr[0] corresponds to instruction bit 12.
  assign cond        = Instr[19:16];
  assign op          = Instr[15:14];
  assign funct       = Instr[13:8];
  assign cmd         = funct[4:1];
  assign imm_bit     = funct[5];
  assign load_bit    = funct[0];
  assign s_bit       = funct[0];
  assign unused_bits = ^Instr[7:0];

  assign flag_n = flags[3];
  assign flag_z = flags[2];
  assign flag_c = flags[1];
  assign flag_v = flags[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (op)
          2'b00:   next_state = imm_bit ? EXECUTEI : EXECUTER;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = load_bit ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  // Condition is sampled once in DECODE and held so mid-instruction flag writes cannot change gating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      if (state == DECODE) cond_ex_r <= cond_ex;
      if (((state == EXECUTER) || (state == EXECUTEI)) && cond_ex_r) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = 2'b00;
    flag_w = 2'b00;
    is_cmp = 1'b0;
    case (cmd)
      4'b0100: begin alu_op = 2'b00; flag_w = {s_bit, s_bit}; end
      4'b0010: begin alu_op = 2'b01; flag_w = {s_bit, s_bit}; end
      4'b0000: begin alu_op = 2'b10; flag_w = {s_bit, 1'b0}; end
      4'b1100: begin alu_op = 2'b11; flag_w = {s_bit, 1'b0}; end
`ifdef ARM_MCC_CMP_EN
      4'b1010: begin alu_op = 2'b01; flag_w = 2'b11; is_cmp = 1'b1; end
`else
      4'b1010: begin alu_op = 2'b00; flag_w = 2'b00; is_cmp = 1'b0; end
`endif
      default: begin alu_op = 2'b00; flag_w = 2'b00; end
    endcase
  end

  always_comb begin
    ir_w       = 1'b0;
    fetch_pc   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state)
      FETCH: begin
        ir_w      = 1'b1;
        fetch_pc  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: ALUControl = alu_op;
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      ALUWB:    reg_w = ~is_cmp;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are killed combinationally while reset is held low.
  assign PCWrite  = reset & (fetch_pc | (branch & cond_ex_r));
  assign IRWrite  = reset & ir_w;
  assign RegWrite = reset & reg_w & cond_ex_r;
  assign MemWrite = reset & mem_w & cond_ex_r;

  assign RegSrc = {(op == 2'b01) & ~load_bit, op == 2'b10};
  assign ImmSrc = op;
  assign State  = state;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Randomized bench for arm_multicycle_controller against an instruction-level reference model.
// Honours ARM_MCC_CMP_EN the same way the design does.
module tb_arm_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
  logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [3:0]  State;

  int checks   = 0;
  int failures = 0;
  logic [3:0] model_flags;

  always #5 clk = ~clk;

  arm_multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] flags_in);
    Instr    = ins[31:12];
    ALUFlags = flags_in;
  endtask

  // ARM condition table: pairs of opposite conditions share a base test, bit 0 inverts.
  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic nf, zf, cf, vf, base;
    nf = f[3]; zf = f[2]; cf = f[1]; vf = f[0];
    case (cc[3:1])
      3'd0: base = zf;
      3'd1: base = cf;
      3'd2: base = nf;
      3'd3: base = vf;
      3'd4: base = cf && !zf;
      3'd5: base = (nf == vf);
      3'd6: base = !zf && (nf == vf);
      default: base = 1'b1;
    endcase
    if (cc == 4'b1111) return 1'b0;
    return base ^ cc[0];
  endfunction

  function automatic logic cmp_cmd(input logic [3:0] cmd);
`ifdef ARM_MCC_CMP_EN
    return cmd == 4'b1010;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] model_alu(input logic [3:0] cmd);
    if (cmd == 4'b0100) return 2'b00;
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    if (cmp_cmd(cmd))   return 2'b01;
    return 2'b00;
  endfunction

  // Returns {PCWrite,IRWrite,MemWrite,RegWrite, AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}.
  function automatic logic [15:0] expect_out(input int st, input logic [31:0] ins, input logic ok, input logic in_reset);
    logic [1:0] op, regsrc, srcb, res, aluc;
    logic [5:0] fn;
    logic pcw, irw, memw, regw, adr, srca;
    op = ins[27:26]; fn = ins[25:20];
    pcw = 0; irw = 0; memw = 0; regw = 0; adr = 0; srca = 0;
    srcb = 2'b00; res = 2'b00; aluc = 2'b00;
    regsrc = {op == 2'b01 && !fn[0], op == 2'b10};
    case (st)
      0: begin pcw = 1; irw = 1; srca = 1; srcb = 2'b10; res = 2'b10; end
      1: begin srca = 1; srcb = 2'b10; res = 2'b10; end
      2: srcb = 2'b01;
      3: adr = 1;
      4: begin res = 2'b01; regw = ok; end
      5: begin adr = 1; memw = ok; end
      6: aluc = model_alu(fn[4:1]);
      7: begin srcb = 2'b01; aluc = model_alu(fn[4:1]); end
      8: regw = ok && !cmp_cmd(fn[4:1]);
      9: begin srcb = 2'b01; res = 2'b10; pcw = ok; end
      default: ;
    endcase
    if (in_reset) begin pcw = 0; irw = 0; memw = 0; regw = 0; end
    return {pcw, irw, memw, regw, adr, regsrc, srca, srcb, res, op, aluc};
  endfunction

  task automatic check_cycle(input string name, input int st, input logic [31:0] ins, input logic ok, input logic in_reset);
    logic [15:0] e;
    e = expect_out(st, ins, ok, in_reset);
    checkOutput($sformatf("%s/s%0d/state", name, st), 32'(State), 32'(st));
    checkOutput($sformatf("%s/s%0d/strobes", name, st),
                32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'(e[15:12]));
    checkOutput($sformatf("%s/s%0d/selects", name, st),
                32'({AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl}), 32'(e[11:0]));
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT in FETCH.
  task automatic run_instr(input string name, input logic [31:0] ins, input logic [3:0] exec_flags);
    int seq[$];
    logic [1:0] op;
    logic [5:0] fn;
    logic ok, nz, cv;
    op = ins[27:26]; fn = ins[25:20];
    case (op)
      2'b00:   seq = fn[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b01:   seq = fn[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b10:   seq = '{0, 1, 9};
      default: seq = '{0, 1};
    endcase
    ok = cond_holds(ins[31:28], model_flags);
    nz = fn[0] && (fn[4:1] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100});
    cv = fn[0] && (fn[4:1] inside {4'b0100, 4'b0010});
    if (cmp_cmd(fn[4:1])) begin nz = 1; cv = 1; end
    foreach (seq[i]) begin
      applyStimulus(ins, (seq[i] == 6 || seq[i] == 7) ? exec_flags : 4'($urandom));
      #1;
      check_cycle(name, seq[i], ins, ok, 1'b0);
      @(posedge clk);
      if ((seq[i] == 6 || seq[i] == 7) && ok) begin
        if (nz) model_flags[3:2] = exec_flags[3:2];
        if (cv) model_flags[1:0] = exec_flags[1:0];
      end
      #1;
    end
  endtask

  // Starts an LDR, pulls reset low in MEMREAD, then releases it one edge later.
  task automatic reset_mid_instr();
    logic [31:0] ins;
    ins = 32'hE591_2004;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(ins, 4'($urandom));
      @(posedge clk);
      #1;
    end
    checkOutput("rst_mid/pre_state", 32'(State), 32'd3);
    #2;
    reset = 1'b0;
    model_flags = 4'b0000;
    #1;
    check_cycle("rst_mid/async", 0, ins, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_cycle("rst_mid/held", 0, ins, 1'b0, 1'b1);
    reset = 1'b1;
  endtask

  initial begin
    model_flags = 4'b0000;
    reset = 1'b0;
    applyStimulus(32'h0, 4'h0);
    #1;
    check_cycle("por", 0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr("add",      32'hE081_2003, 4'($urandom));
    run_instr("subs_z",   32'hE051_1001, 4'b0100);
    run_instr("beq_t",    32'h0A00_0002, 4'h0);
    run_instr("subs_nz",  32'hE051_1001, 4'b0000);
    run_instr("beq_nt",   32'h0A00_0002, 4'h0);
    run_instr("ldr",      32'hE591_2004, 4'h0);
    run_instr("str",      32'hE581_2004, 4'h0);
    run_instr("subs_z2",  32'hE051_1001, 4'b0100);
    run_instr("addne",    32'h1081_2003, 4'b0000);
    run_instr("beq_held", 32'h0A00_0002, 4'h0);
    run_instr("subs_nz2", 32'hE051_1001, 4'b0000);
    run_instr("cmp",      32'hE151_0002, 4'b0100);
    run_instr("beq_cmp",  32'h0A00_0002, 4'h0);
    run_instr("op11",     32'hEC00_0000, 4'h0);
    run_instr("al_nv",    32'hF081_2003, 4'($urandom));
    run_instr("subs_z3",  32'hE051_1001, 4'b0100);
    reset_mid_instr();
    run_instr("beq_rst",  32'h0A00_0002, 4'h0);

    for (int n = 0; n < 60; n++) begin
      run_instr($sformatf("rnd%0d", n), $urandom, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
